// File: rtl/serial_rx_lanes_pkg.sv
// Shared types and default geometry for the multi-lane serial frame receiver.
package serial_rx_lanes_pkg;

  // Header lane beat 0 selects the frame kind.
  typedef enum logic {
    FRAME_DATA = 1'b0,
    FRAME_ACK  = 1'b1
  } frame_type_t;

  // Receiver FSM states; one serial beat moves the FSM by at most one state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int DEF_DATA_LANES  = 4;
  localparam int DEF_FRAME_BEATS = 8;
  localparam int DEF_SEQ_BITS    = 1;

endpackage

// File: rtl/serial_sync.sv
// Two-flop synchroniser for the serial bundle. Bit 0 carries the serial
// clock; a third flop on it produces a one-cycle rising-edge strobe. The
// remaining bits are handed on synchronised so they can be sampled on that
// strobe. All flops come out of reset at 1, matching the idle line level.
module serial_sync #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:1] q,
  output logic         rise
);

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic         sync3;

  // Metastability chain plus the extra stage used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      sync3 <= sync2[0];
    end
  end

  assign q    = sync2[N-1:1];
  assign rise = sync2[0] & ~sync3;

endmodule

// File: rtl/serial_rx_lanes.sv
// Multi-lane serial frame receiver: deframes start/payload/parity/stop frames
// sampled on rising edges of an external serial clock, checks per-lane even
// parity, classifies DATA/ACK frames, drops duplicate DATA by sequence number
// and keeps wrap/saturate counters for debug displays.
//
// Output handshake: every *_valid / pulse output (payload_valid, ack_received,
// send_ack, frame_err) is a single-cycle strobe with no back-pressure; the
// associated data (payload, ack_seqNum, send_ack_seqNum, counters) is stable
// in the same cycle as the strobe and holds until the next update.
module serial_rx_lanes
  import serial_rx_lanes_pkg::*;
#(
  parameter int DATA_LANES     = DEF_DATA_LANES,
  parameter int FRAME_BEATS    = DEF_FRAME_BEATS,
  parameter int SEQ_BITS       = DEF_SEQ_BITS,
  parameter int CNT_BITS       = 4,
  parameter int ERR_BITS       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              game_active,
  input  logic                              serial_clk,
  input  logic                              serial_in_h,
  input  logic [DATA_LANES-1:0]             serial_in,
  output logic [DATA_LANES*FRAME_BEATS-1:0] payload,
  output logic                              payload_valid,
  output logic                              ack_received,
  output logic [SEQ_BITS-1:0]               ack_seqNum,
  output logic                              send_ack,
  output logic [SEQ_BITS-1:0]               send_ack_seqNum,
  output logic                              frame_err,
  output logic [CNT_BITS-1:0]               packets_received_cnt,
  output logic [ERR_BITS-1:0]               err_cnt
);

  localparam int PW = DATA_LANES * FRAME_BEATS;
  localparam int BW = (FRAME_BEATS > 2) ? $clog2(FRAME_BEATS) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW = SEQ_BITS + 1;

  // lanes[0] is the header lane, lanes[DATA_LANES:1] the data lanes.
  logic [DATA_LANES:0] lanes;
  logic                beat;

  serial_sync #(.N(DATA_LANES + 2)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    ({serial_in, serial_in_h, serial_clk}),
    .q    (lanes),
    .rise (beat)
  );

  rx_state_t           rx_state;
  rx_state_t           rx_state_nxt;
  logic [BW-1:0]       beat_cnt;
  logic [PW-1:0]       data_sr;
  logic [HW-1:0]       hdr_sr;
  logic [DATA_LANES:0] par_acc;
  logic                par_err;
  logic [WW-1:0]       wd_q;
  logic                last_valid;
  logic [SEQ_BITS-1:0] last_seq;

  logic                last_beat;
  logic                timeout;
  logic                start_frame;
  logic                shift_en;
  logic                parity_en;
  logic                decide_en;

  frame_type_t         frame_type;
  logic [SEQ_BITS-1:0] frame_seq;
  logic                frame_bad;
  logic                seq_is_new;

  assign last_beat  = (beat_cnt == BW'(FRAME_BEATS - 1));
  assign timeout    = (rx_state != IDLE) && !beat && (wd_q == WW'(TIMEOUT_CYCLES - 1));
  assign frame_type = frame_type_t'(hdr_sr[SEQ_BITS]);
  assign frame_seq  = hdr_sr[SEQ_BITS-1:0];
  assign frame_bad  = !lanes[0] || par_err;
  assign seq_is_new = !last_valid || (frame_seq != last_seq);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= IDLE;
    else     rx_state <= rx_state_nxt;
  end

  // FSM next state: advances only on serial beats; the watchdog aborts to IDLE.
  always_comb begin
    rx_state_nxt = rx_state;
    if (timeout) begin
      rx_state_nxt = IDLE;
    end else if (beat) begin
      case (rx_state)
        IDLE:    if (!lanes[0]) rx_state_nxt = RECV;
        RECV:    if (last_beat) rx_state_nxt = PARITY;
        PARITY:  rx_state_nxt = STOP;
        STOP:    rx_state_nxt = IDLE;
        default: rx_state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: per-state strobes that steer the datapath on a beat.
  always_comb begin
    start_frame = 1'b0;
    shift_en    = 1'b0;
    parity_en   = 1'b0;
    decide_en   = 1'b0;
    if (beat) begin
      case (rx_state)
        IDLE:    start_frame = !lanes[0];
        RECV:    shift_en    = 1'b1;
        PARITY:  parity_en   = 1'b1;
        STOP:    decide_en   = 1'b1;
        default: ;
      endcase
    end
  end

  // Frame capture: payload/header shift registers and running lane parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      data_sr  <= '0;
      hdr_sr   <= '0;
      par_acc  <= '0;
      par_err  <= 1'b0;
    end else if (start_frame) begin
      beat_cnt <= '0;
      par_acc  <= '0;
      par_err  <= 1'b0;
    end else if (shift_en) begin
      beat_cnt <= beat_cnt + 1'b1;
      data_sr  <= {data_sr[PW-DATA_LANES-1:0], lanes[DATA_LANES:1]};
      par_acc  <= par_acc ^ lanes;
      // Only type and sequence bits are kept; reserved header beats are ignored.
      if (int'(beat_cnt) <= SEQ_BITS) hdr_sr <= {hdr_sr[SEQ_BITS-1:0], lanes[0]};
    end else if (parity_en) begin
      par_err <= |(par_acc ^ lanes);
    end
  end

  // Watchdog: clk cycles since the last beat while a frame is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      wd_q <= '0;
    else if (rx_state == IDLE || beat || timeout) wd_q <= '0;
    else                                          wd_q <= wd_q + 1'b1;
  end

  // Frame decision and registered outputs, one clk after the stop beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      payload              <= '0;
      payload_valid        <= 1'b0;
      ack_received         <= 1'b0;
      ack_seqNum           <= '0;
      send_ack             <= 1'b0;
      send_ack_seqNum      <= '0;
      frame_err            <= 1'b0;
      packets_received_cnt <= '0;
      err_cnt              <= '0;
      last_valid           <= 1'b0;
      last_seq             <= '0;
    end else begin
      payload_valid <= 1'b0;
      ack_received  <= 1'b0;
      send_ack      <= 1'b0;
      frame_err     <= 1'b0;
      if (timeout || (decide_en && frame_bad)) begin
        frame_err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else if (decide_en && game_active) begin
        if (frame_type == FRAME_ACK) begin
          ack_received <= 1'b1;
          ack_seqNum   <= frame_seq;
        end else begin
          send_ack        <= 1'b1;
          send_ack_seqNum <= frame_seq;
          if (seq_is_new) begin
            payload              <= data_sr;
            payload_valid        <= 1'b1;
            packets_received_cnt <= packets_received_cnt + 1'b1;
            last_seq             <= frame_seq;
            last_valid           <= 1'b1;
          end
        end
      end
    end
  end

endmodule
